// File: rtl/ps2_key_controller_if.sv
// rtl/ps2_key_controller_if.sv - scan-byte input and command FIFO handshake bundle for ps2_key_controller
interface ps2_key_controller_if;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] key_held;
    logic       cmd_dropped;

    modport master (
        output scan_code, scan_valid, cmd_ready,
        input  cmd, cmd_valid, key_held, cmd_dropped
    );

    modport slave (
        input  scan_code, scan_valid, cmd_ready,
        output cmd, cmd_valid, key_held, cmd_dropped
    );
endinterface

// File: rtl/ps2_key_controller.sv
// rtl/ps2_key_controller.sv - PS/2 set-2 scan bytes to Tetris commands with a 4-entry command FIFO
// Define AUTO_REPEAT_EN to add DAS/ARR auto-shift for LEFT, RIGHT and SOFT_DROP.
module ps2_key_controller #(
    parameter int DAS_CYCLES = 12_000_000,
    parameter int ARR_CYCLES = 3_000_000
) (
    input  logic              clk_in,
    input  logic              reset_in,
    ps2_key_controller_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BREAK, S_EXT_BREAK} state_t;

    state_t     r_state;
    state_t     w_state_n;
    logic [2:0] r_mem [4];
    logic [1:0] r_rd;
    logic [1:0] r_wr;
    logic [2:0] r_count;
    logic [2:0] r_cmd;
    logic       r_cmd_valid;
    logic [6:0] r_held;
    logic       r_dropped;

    logic       w_dec;
    logic       w_dec_ext;
    logic       w_dec_brk;
    logic [2:0] w_key;
    logic [6:0] w_key_mask;
    logic       w_make;
    logic       w_brk;
    logic [6:0] w_held_n;
    logic       w_rep_push;
    logic [2:0] w_rep_cmd;
    logic       w_push;
    logic [2:0] w_push_cmd;
    logic       w_pop;
    logic       w_push_ok;
    logic [2:0] w_count_n;
    logic [1:0] w_rd_n;
    logic [2:0] w_head_n;

    function automatic logic [2:0] map_key(input logic ext, input logic [7:0] code);
        if (ext) begin
            case (code)
                8'h6B:   return 3'd1;
                8'h74:   return 3'd2;
                8'h75:   return 3'd3;
                8'h72:   return 3'd5;
                default: return 3'd0;
            endcase
        end else begin
            case (code)
                8'h1A:   return 3'd4;
                8'h29:   return 3'd6;
                8'h4D:   return 3'd7;
                default: return 3'd0;
            endcase
        end
    endfunction

    always_comb begin
        w_state_n = r_state;
        w_dec     = 1'b0;
        w_dec_ext = 1'b0;
        w_dec_brk = 1'b0;
        if (bus.scan_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.scan_code == 8'hE0)      w_state_n = S_EXT;
                    else if (bus.scan_code == 8'hF0) w_state_n = S_BREAK;
                    else                             w_dec = 1'b1;
                end
                S_EXT: begin
                    if (bus.scan_code == 8'hF0)      w_state_n = S_EXT_BREAK;
                    else if (bus.scan_code == 8'hE0) w_state_n = S_EXT;
                    else begin
                        w_dec     = 1'b1;
                        w_dec_ext = 1'b1;
                        w_state_n = S_IDLE;
                    end
                end
                S_BREAK: begin
                    w_dec     = 1'b1;
                    w_dec_brk = 1'b1;
                    w_state_n = S_IDLE;
                end
                S_EXT_BREAK: begin
                    w_dec     = 1'b1;
                    w_dec_ext = 1'b1;
                    w_dec_brk = 1'b1;
                    w_state_n = S_IDLE;
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    // A make of an already-held key is keyboard typematic and is swallowed.
    assign w_key      = w_dec ? map_key(w_dec_ext, bus.scan_code) : 3'd0;
    assign w_key_mask = (w_key == 3'd0) ? 7'd0 : (7'd1 << (w_key - 3'd1));
    assign w_make     = !w_dec_brk && (w_key != 3'd0) && ((r_held & w_key_mask) == 7'd0);
    assign w_brk      = w_dec_brk && (w_key != 3'd0);
    assign w_held_n   = w_make ? (r_held | w_key_mask) :
                        w_brk  ? (r_held & ~w_key_mask) : r_held;

`ifdef AUTO_REPEAT_EN
    logic [2:0]  r_active;
    logic        r_arr;
    logic [31:0] r_cnt;
    logic [31:0] w_term;
    logic        w_kill;
    logic        w_repeatable;

    assign w_repeatable = (w_key == 3'd1) || (w_key == 3'd2) || (w_key == 3'd5);
    assign w_term       = r_arr ? 32'(ARR_CYCLES - 1) : 32'(DAS_CYCLES - 1);
    assign w_kill       = w_brk && (w_key == r_active);
    // The counter parks on its terminal value while a parser push holds the slot.
    assign w_rep_push   = (r_active != 3'd0) && (r_cnt == w_term) && !w_make && !w_kill;
    assign w_rep_cmd    = r_active;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_active <= 3'd0;
            r_arr    <= 1'b0;
            r_cnt    <= 32'd0;
        end else if (w_make && w_repeatable) begin
            r_active <= w_key;
            r_arr    <= 1'b0;
            r_cnt    <= 32'd0;
        end else if (w_kill) begin
            r_active <= 3'd0;
            r_cnt    <= 32'd0;
        end else if (r_active != 3'd0) begin
            if (r_cnt == w_term) begin
                if (!w_make) begin
                    r_cnt <= 32'd0;
                    r_arr <= 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^{DAS_CYCLES[1:0], ARR_CYCLES[1:0]};
    assign w_rep_push   = 1'b0;
    assign w_rep_cmd    = 3'd0;
`endif

    assign w_push     = w_make || w_rep_push;
    assign w_push_cmd = w_make ? w_key : w_rep_cmd;
    assign w_pop      = r_cmd_valid && bus.cmd_ready;
    assign w_push_ok  = w_push && ((r_count != 3'd4) || w_pop);
    assign w_count_n  = r_count + {2'b00, w_push_ok} - {2'b00, w_pop};
    assign w_rd_n     = r_rd + {1'b0, w_pop};

    // The new head is the entry being pushed only when the queue would otherwise be empty.
    always_comb begin
        w_head_n = 3'd0;
        if (w_count_n != 3'd0) begin
            if (w_push_ok && (w_rd_n == r_wr)) w_head_n = w_push_cmd;
            else                               w_head_n = r_mem[w_rd_n];
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state     <= S_IDLE;
            r_rd        <= 2'd0;
            r_wr        <= 2'd0;
            r_count     <= 3'd0;
            r_cmd       <= 3'd0;
            r_cmd_valid <= 1'b0;
            r_held      <= 7'd0;
            r_dropped   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_held  <= w_held_n;
            if (w_push_ok) begin
                r_mem[r_wr] <= w_push_cmd;
                r_wr        <= r_wr + 2'd1;
            end
            r_rd        <= w_rd_n;
            r_count     <= w_count_n;
            r_cmd       <= w_head_n;
            r_cmd_valid <= (w_count_n != 3'd0);
            r_dropped   <= w_push && !w_push_ok;
        end
    end

    assign bus.cmd         = r_cmd;
    assign bus.cmd_valid   = r_cmd_valid;
    assign bus.key_held    = r_held;
    assign bus.cmd_dropped = r_dropped;
endmodule

// File: tb/tb_ps2_key_controller.sv
// tb/tb_ps2_key_controller.sv - randomized and directed bench for ps2_key_controller against a queue-based reference model
module tb_ps2_key_controller;
    localparam int DAS = 20;
    localparam int ARR = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_key_controller_if bus();

    ps2_key_controller #(.DAS_CYCLES(DAS), .ARR_CYCLES(ARR)) dut (
        .clk_in   (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int       m_q[$];
    bit [6:0] m_held;
    bit       m_ext;
    bit       m_brk;
    int       m_active;
    longint   m_due;
    bit       m_drop;
    longint   cyc = 0;

    // observation tallies
    int npop [8];
    int ndrop;
    int last_pop;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int map_key(input bit ext, input logic [7:0] c);
        if (ext) begin
            if (c == 8'h6B) return 1;
            if (c == 8'h74) return 2;
            if (c == 8'h75) return 3;
            if (c == 8'h72) return 5;
        end else begin
            if (c == 8'h1A) return 4;
            if (c == 8'h29) return 6;
            if (c == 8'h4D) return 7;
        end
        return 0;
    endfunction

    task automatic model_edge(input bit sv, input logic [7:0] b, input bit rdy, input bit r);
        int  k;
        int  ppush;
        int  push;
        bit  pop;
        if (r) begin
            m_q.delete();
            m_held   = '0;
            m_ext    = 0;
            m_brk    = 0;
            m_active = 0;
            m_drop   = 0;
            return;
        end
        pop   = (m_q.size() > 0) && rdy;
        ppush = 0;
        if (sv) begin
            if (!m_brk && b == 8'hE0) m_ext = 1;
            else if (!m_brk && b == 8'hF0) m_brk = 1;
            else begin
                k = map_key(m_ext, b);
                if (k != 0) begin
                    if (m_brk) begin
                        m_held[k-1] = 0;
                        if (k == m_active) m_active = 0;
                    end else if (!m_held[k-1]) begin
                        m_held[k-1] = 1;
                        ppush = k;
`ifdef AUTO_REPEAT_EN
                        if (k == 1 || k == 2 || k == 5) begin
                            m_active = k;
                            m_due    = cyc + DAS;
                        end
`endif
                    end
                end
                m_ext = 0;
                m_brk = 0;
            end
        end
        push = ppush;
`ifdef AUTO_REPEAT_EN
        if (ppush == 0 && m_active != 0 && cyc >= m_due) begin
            push  = m_active;
            m_due = cyc + ARR;
        end
`endif
        m_drop = (push != 0) && (m_q.size() == 4) && !pop;
        if (pop) void'(m_q.pop_front());
        if (push != 0 && !m_drop) m_q.push_back(push);
    endtask

    task automatic compare();
        check("cmd_valid", int'(bus.cmd_valid), int'(m_q.size() > 0));
        if (m_q.size() > 0) check("cmd", int'(bus.cmd), m_q[0]);
        check("key_held", int'(bus.key_held), int'(m_held));
        check("cmd_dropped", int'(bus.cmd_dropped), int'(m_drop));
    endtask

    task automatic step(input bit sv, input logic [7:0] b, input bit rdy, input bit r);
        bus.scan_valid = sv;
        bus.scan_code  = b;
        bus.cmd_ready  = rdy;
        rst            = r;
        if (!r && bus.cmd_valid && rdy) begin
            npop[bus.cmd]++;
            last_pop = int'(bus.cmd);
        end
        @(posedge clk);
        model_edge(sv, b, rdy, r);
        cyc++;
        @(negedge clk);
        compare();
        if (bus.cmd_dropped) ndrop++;
        bus.scan_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit rdy);
        step(1'b1, b, rdy, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy, 1'b0);
    endtask

    task automatic clear_tally();
        for (int i = 0; i < 8; i++) npop[i] = 0;
        ndrop    = 0;
        last_pop = 0;
    endtask

    logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72,
                              8'h1A, 8'h29, 8'h4D, 8'hE0, 8'hF0, 8'hAA};

    initial begin
        int exp_rep;
        bus.scan_valid = 1'b0;
        bus.scan_code  = 8'h00;
        bus.cmd_ready  = 1'b0;
        rst            = 1'b1;
        clear_tally();

        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("reset_cmd", int'(bus.cmd), 0);

        // extended make with typematic repeats
        clear_tally();
        for (int i = 0; i < 3; i++) begin
            send(8'hE0, 1); send(8'h75, 1); idle(2, 1);
        end
        check("t1_one_rot_cw", npop[3], 1);
        send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1); idle(2, 1);
        check("t1_released", int'(bus.key_held[2]), 0);

        // prefix separation
        clear_tally();
        send(8'h6B, 1); idle(3, 1);
        check("t2_plain_6b", npop[1], 0);
        send(8'hE0, 1); send(8'h6B, 1); idle(3, 1);
        check("t2_ext_6b", npop[1], 1);
        send(8'hF0, 1); send(8'h1A, 1); idle(3, 1);
        check("t2_break_unheld", npop[4], 0);
        send(8'hE0, 1); send(8'hF0, 1); send(8'h6B, 1); idle(2, 1);

        // auto-repeat of RIGHT, released before the fourth ARR repeat
        clear_tally();
        send(8'hE0, 1); send(8'h74, 1);
        idle(29, 1);
        send(8'hE0, 1); send(8'hF0, 1); send(8'h74, 1);
        idle(40, 1);
`ifdef AUTO_REPEAT_EN
        exp_rep = 4;
`else
        exp_rep = 1;
`endif
        check("t3_right_pushes", npop[2], exp_rep);

        // FIFO overflow
        clear_tally();
        for (int i = 0; i < 5; i++) begin
            send(8'h29, 0); send(8'hF0, 0); send(8'h29, 0);
        end
        check("t4_drop_pulses", ndrop, 1);
        idle(8, 1);
        check("t4_pops", npop[6], 4);
        check("t4_empty", int'(bus.cmd_valid), 0);

        // full queue with push and pop in the same cycle
        clear_tally();
        for (int i = 0; i < 4; i++) begin
            send(8'h29, 0); send(8'hF0, 0); send(8'h29, 0);
        end
        send(8'h4D, 1);
        idle(6, 1);
        check("t5_no_drop", ndrop, 0);
        check("t5_pops6", npop[6], 4);
        check("t5_pops7", npop[7], 1);
        check("t5_last", last_pop, 7);
        send(8'hF0, 1); send(8'h4D, 1);

        // reset mid-sequence
        clear_tally();
        send(8'hE0, 1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        send(8'h6B, 1); idle(3, 1);
        check("t6_no_left", npop[1], 0);
        send(8'h6B, 0); send(8'h29, 0); send(8'hE0, 0); send(8'h75, 0); idle(1, 0);
        check("t6_pre_held", int'(bus.key_held), 'h24);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t6_cmd", int'(bus.cmd), 0);
        check("t6_valid", int'(bus.cmd_valid), 0);
        check("t6_held", int'(bus.key_held), 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] b;
            bit sv, rdy, r;
            sv  = ($urandom_range(0, 2) == 0);
            b   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
            rdy = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 399) == 0);
            step(sv, b, rdy, r);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
